debug_display_ctrl: RTL

DEBUG_DISPLAY_CTRL -- requirements
Module: debug_display_ctrl

---
 rtl/debug_display_pkg.sv | 31 +++
 rtl/hex7seg.sv | 31 +++
 rtl/debug_display_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/debug_display_pkg.sv
// rtl/debug_display_pkg.sv - shared types and constants for the debug 7-segment display
package debug_display_pkg;

    typedef enum logic {
        SCAN  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam int DEFAULT_REFRESH_DIV = 100000;
    localparam int DEFAULT_ACK_TIMEOUT = 255;

    // Active-low segments, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex digit to active-low 7-segment decoder
module hex7seg
    import debug_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/debug_display_ctrl.sv
// rtl/debug_display_ctrl.sv - 4-digit multiplexed display of PC or a register-file word
module debug_display_ctrl
    import debug_display_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        disp_pc,
    input  logic [4:0]  reg_index,
    input  logic [31:0] pc_value,
    output logic        rf_rd_req,
    output logic [4:0]  rf_rd_addr,
    input  logic        rf_rd_ack,
    input  logic [31:0] rf_rd_data,
    output logic        stale,
    output logic [3:0]  anodes,
    output logic [6:0]  cathodes
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(ACK_TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic [RW-1:0]   refresh_cnt;
    logic [1:0]      digit_idx;
    logic [TW-1:0]   wait_cnt;
    logic [15:0]     disp_val;
    logic [3:0]      nibble;
    logic [6:0]      glyph;
    logic            tick;
    logic            frame_start;
    logic            load_pc;
    logic            start_fetch;
    logic            fetch_ok;
    logic            fetch_to;
    logic            unused_hi_bits;

    assign unused_hi_bits = ^{pc_value[31:16], rf_rd_data[31:16]};

    assign tick        = (refresh_cnt == REFRESH_MAX);
    assign frame_start = tick && (digit_idx == 2'd3);
    assign nibble      = disp_val[{digit_idx, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (glyph)
    );

    // The digit lit on a tick is the one digit_idx points at; the index then moves on.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            anodes      <= 4'b1111;
            cathodes    <= SEG_BLANK;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + RW'(1);
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
                anodes    <= ~(4'b0001 << digit_idx);
                cathodes  <= glyph;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_pc     = 1'b0;
        start_fetch = 1'b0;
        fetch_ok    = 1'b0;
        fetch_to    = 1'b0;
        case (state)
            SCAN: begin
                if (frame_start) begin
                    if (disp_pc) begin
                        load_pc = 1'b1;
                    end else begin
                        start_fetch = 1'b1;
                        state_next  = FETCH;
                    end
                end
            end
            FETCH: begin
                if (rf_rd_ack) begin
                    fetch_ok   = 1'b1;
                    state_next = SCAN;
                end else if (wait_cnt == TIMEOUT_MAX) begin
                    fetch_to   = 1'b1;
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Request is decoded from the state so an async reset drops it at once.
    assign rf_rd_req = (state == FETCH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_rd_addr <= 5'd0;
            wait_cnt   <= '0;
            disp_val   <= 16'h0000;
            stale      <= 1'b0;
        end else begin
            if (start_fetch) begin
                rf_rd_addr <= reg_index;
                wait_cnt   <= '0;
            end else if (state == FETCH) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (load_pc) begin
                disp_val <= pc_value[15:0];
                stale    <= 1'b0;
            end else if (fetch_ok) begin
                disp_val <= rf_rd_data[15:0];
                stale    <= 1'b0;
            end else if (fetch_to) begin
                stale <= 1'b1;
            end
        end
    end

endmodule
